fp_div_iter: RTL and testbench
==============================

# fp_div_iter

Iterative single-precision IEEE-754 floating-point divider, the inverse-operation companion to the 3-stage pipelined FP multiplier in the arithmetic experiments. It computes a/b with a radix-2 restoring mantissa divider, producing one quotient bit per cycle. It uses a valid/ready handshake on both input and output. Special-case encoding and flags match the multiplier: exception → signed zero, overflow → signed infinity, underflow → signed zero.

## Interface
Parameters: none.

- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- in_valid  in  1  operands a, b valid
- in_ready  out  1  divider idle and accepting
- a  in  32  dividend, IEEE-754 single
- b  in  32  divisor, IEEE-754 single
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts result
- result  out  32  quotient
- exception  out  1  either input exponent is 8'hFF
- overflow  out  1  result exponent ≥ 255
- underflow  out  1  result exponent ≤ 0
- div_by_zero  out  1  divisor is zero or denormal, with no exception

## Operation
- States: IDLE, DIVIDE, NORM, DONE.
- **Reset**: state→IDLE; result, all flags, out_valid→0. in_ready=0 while reset is high. Reset in any state abandons the operation; no out_valid is produced.
- **IDLE**: in_ready=1. Accept on in_valid&in_ready and capture:
  - sign=a[31]^b[31]
  - exc=(&ea)|(&eb)
  - ma={1,a[22:0]}, mb={1,b[22:0]}
  - e = ea − eb + 127, as 10-bit signed
- **Denormals**: flushed. ea==0 makes a zero; eb==0 makes b zero.
- **Special cases at accept** (priority order; go directly to DONE):
  - exc → {sign,31'd0}, exception=1.
  - b zero → {sign,8'hFF,23'd0}, div_by_zero=1.
  - a zero → {sign,31'd0}, no flags.
- **DIVIDE**: 5-bit counter runs 25→0; remainder r is 25 bits, initialised to ma. Each cycle:
  - if r ≥ mb: q bit=1, r=(r−mb)<<1
  - else: q bit=0, r=r<<1
  - Bits fill q[25:0] MSB first. Exit to NORM after counter==0.
- **NORM** (single cycle):
  - If q[25]=1: mant=q[24:2], guard=q[1], sticky=q[0]|(r≠0), exp=e.
  - Else: mant=q[23:1], guard=q[0], sticky=(r≠0), exp=e−1.
  - Round to nearest even: increment when guard&(sticky|mant[0]). If mant==all-ones and incremented: mant=0, exp+1.
  - exp ≥ 255 → {sign,8'hFF,23'd0}, overflow=1.
  - exp ≤ 0 → {sign,31'd0}, underflow=1.
  - Otherwise → {sign,exp[7:0],mant}.
- **DONE**: out_valid=1. result and flags are stable until out_valid&out_ready, then go to IDLE.
  - result and flags retain their value after the handshake until the next result is written.
  - Flags are cleared at each accept; at most one flag is set per result.

## Timing
- Accept at edge T:
  - DIVIDE occupies cycles T+1..T+26.
  - NORM occupies T+27.
  - out_valid=1 from T+28.
  - Normal-path latency is 28 cycles.
- Special cases: out_valid=1 from T+1; latency is 1 cycle.
- in_ready=0 from T+1 until the cycle after the output handshake. Throughput is at most one operation per 29 cycles.
- Output handshake at edge H: out_valid=0 and in_ready=1 at H+1. There is no same-cycle accept of a new operation during DONE.
- in_valid while busy is ignored; operands are not buffered.
- out_ready held low: the block holds in DONE indefinitely, with result and flags unchanged.

## Test plan
- 6.0/2.0: a=0x40C00000, b=0x40000000 → result 0x40400000, no flags, out_valid exactly 28 cycles after accept. Also 1.0/1.0 (0x3F800000 / 0x3F800000) → 0x3F800000.
- 1.0/3.0: 0x3F800000 / 0x40400000 → 0x3EAAAAAB (checks q[25]=0 normalisation and the round-up). Also 2.0/3.0 → 0x3F2AAAAB.
- Specials:
  - 0xBF800000/0x00000000 → 0xFF800000, div_by_zero=1, out_valid at T+1.
  - 0x7F800000/0x3F800000 → 0x00000000, exception=1.
  - 0x00000000/0x40000000 → 0x00000000, no flags.
- Range: 0x7F000000/0x00800000 → 0x7F800000, overflow=1. 0x00800000/0x7F000000 → 0x00000000, underflow=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → result, flags and out_valid stable, in_ready=0. Pulse out_ready → in_ready=1 the next cycle, and a back-to-back second op (6.0/2.0) is correct.
- Reset mid-DIVIDE (cycle T+10) → out_valid never asserts, outputs 0, in_ready=1 the cycle after reset deasserts. A new op then completes correctly.

Source files
------------

// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 single-precision divider: radix-2 restoring mantissa divide,
// one quotient bit per cycle, valid/ready handshakes on input and output.
module fp_div_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        exception,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_NORM   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic               sign_r;
    logic signed [9:0]  exp_r;
    logic [23:0]        mb_r;
    logic [24:0]        r_r;
    logic [25:0]        q_r;
    logic [4:0]         cnt_r;
    logic [31:0]        result_r;
    logic               exception_r, overflow_r, underflow_r, div_by_zero_r;

    logic [7:0]         ea_s, eb_s;
    logic               exc_s, a_zero_s, b_zero_s, accept_s;
    logic signed [9:0]  exp_in_s;
    logic               ge_s;
    logic [23:0]        diff_s;
    logic [24:0]        r_step_s;
    logic [22:0]        mant_s;
    logic               guard_s, sticky_s, inc_s;
    logic [23:0]        mant_rnd_s;
    logic signed [9:0]  exp_n_s, exp_rnd_s;

    assign ea_s     = a[30:23];
    assign eb_s     = b[30:23];
    assign exc_s    = (&ea_s) | (&eb_s);
    assign a_zero_s = (ea_s == 8'd0);
    assign b_zero_s = (eb_s == 8'd0);
    assign exp_in_s = $signed({2'b00, ea_s}) - $signed({2'b00, eb_s}) + 10'sd127;
    assign in_ready = (state_r == ST_IDLE) & ~reset;
    assign accept_s = in_valid & in_ready;
    assign out_valid   = (state_r == ST_DONE);
    assign result      = result_r;
    assign exception   = exception_r;
    assign overflow    = overflow_r;
    assign underflow   = underflow_r;
    assign div_by_zero = div_by_zero_r;

    // Restoring divide step; the true difference is below mb so 24 bits suffice.
    always_comb begin
        ge_s     = (r_r >= {1'b0, mb_r});
        diff_s   = r_r[23:0] - mb_r;
        r_step_s = ge_s ? {diff_s, 1'b0} : {r_r[23:0], 1'b0};
    end

    // Normalise on the quotient's integer bit, then round to nearest even.
    always_comb begin
        if (q_r[25]) begin
            mant_s   = q_r[24:2];
            guard_s  = q_r[1];
            sticky_s = q_r[0] | (r_r != 25'd0);
            exp_n_s  = exp_r;
        end else begin
            mant_s   = q_r[23:1];
            guard_s  = q_r[0];
            sticky_s = (r_r != 25'd0);
            exp_n_s  = exp_r - 10'sd1;
        end
        inc_s      = guard_s & (sticky_s | mant_s[0]);
        mant_rnd_s = {1'b0, mant_s} + {23'd0, inc_s};
        exp_rnd_s  = mant_rnd_s[23] ? (exp_n_s + 10'sd1) : exp_n_s;
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = (exc_s | a_zero_s | b_zero_s) ? ST_DONE : ST_DIVIDE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DIVIDE: begin
                if (cnt_r == 5'd0) begin
                    state_s = ST_NORM;
                end else begin
                    state_s = ST_DIVIDE;
                end
            end
            ST_NORM: state_s = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, divide iterations and result/flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sign_r        <= 1'b0;
            exp_r         <= 10'sd0;
            mb_r          <= 24'd0;
            r_r           <= 25'd0;
            q_r           <= 26'd0;
            cnt_r         <= 5'd0;
            result_r      <= 32'd0;
            exception_r   <= 1'b0;
            overflow_r    <= 1'b0;
            underflow_r   <= 1'b0;
            div_by_zero_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        sign_r        <= a[31] ^ b[31];
                        exp_r         <= exp_in_s;
                        mb_r          <= {1'b1, b[22:0]};
                        r_r           <= {2'b01, a[22:0]};
                        q_r           <= 26'd0;
                        cnt_r         <= 5'd25;
                        exception_r   <= 1'b0;
                        overflow_r    <= 1'b0;
                        underflow_r   <= 1'b0;
                        div_by_zero_r <= 1'b0;
                        if (exc_s) begin
                            result_r    <= {a[31] ^ b[31], 31'd0};
                            exception_r <= 1'b1;
                        end else if (b_zero_s) begin
                            result_r      <= {a[31] ^ b[31], 8'hFF, 23'd0};
                            div_by_zero_r <= 1'b1;
                        end else if (a_zero_s) begin
                            result_r <= {a[31] ^ b[31], 31'd0};
                        end
                    end
                end
                ST_DIVIDE: begin
                    r_r   <= r_step_s;
                    q_r   <= {q_r[24:0], ge_s};
                    cnt_r <= cnt_r - 5'd1;
                end
                ST_NORM: begin
                    if (exp_rnd_s >= 10'sd255) begin
                        result_r   <= {sign_r, 8'hFF, 23'd0};
                        overflow_r <= 1'b1;
                    end else if (exp_rnd_s <= 10'sd0) begin
                        result_r    <= {sign_r, 31'd0};
                        underflow_r <= 1'b1;
                    end else begin
                        result_r <= {sign_r, exp_rnd_s[7:0], mant_rnd_s[22:0]};
                    end
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed, table-driven bench for fp_div_iter with hand-computed quotients,
// plus backpressure and mid-divide reset sequences.
module tb_fp_div_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        exception, overflow, underflow, div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    fp_div_iter dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .exception(exception), .overflow(overflow),
        .underflow(underflow), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;   // {exception, overflow, underflow, div_by_zero}
        int          lat;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [3:0] flags_now();
        return {exception, overflow, underflow, div_by_zero};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Accept one operation and count edges until out_valid (bounded).
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        a = ta; b = tb_v; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
        check({name, "_out_valid_after"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] hold_res;
        logic [3:0]  hold_flags;
        logic        stable;
        logic        seen;

        vecs[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28};
        vecs[1] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 28};
        vecs[2] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28};
        vecs[3] = '{32'h40000000, 32'h40400000, 32'h3F2AAAAB, 4'b0000, 28};
        vecs[4] = '{32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0001, 1};
        vecs[5] = '{32'h7F800000, 32'h3F800000, 32'h00000000, 4'b1000, 1};
        vecs[6] = '{32'h00000000, 32'h40000000, 32'h00000000, 4'b0000, 1};
        vecs[7] = '{32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0100, 28};
        vecs[8] = '{32'h00800000, 32'h7F000000, 32'h00000000, 4'b0010, 28};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 32'd0; b = 32'd0;
        #1;
        check("in_ready_during_reset", {31'd0, in_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_flags", {28'd0, flags_now()}, 32'd0);
        check("in_ready_during_reset_2", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_result", i), result, vecs[i].res);
            check($sformatf("v%0d_flags", i), {28'd0, flags_now()}, {28'd0, vecs[i].flags});
            handshake($sformatf("v%0d", i));
        end

        // Backpressure: hold DONE for 10 cycles, then a back-to-back op.
        run_op(32'h3F800000, 32'h40400000, lat);
        check("bp_latency", lat, 28);
        hold_res = result; hold_flags = flags_now(); stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (result !== hold_res || flags_now() !== hold_flags || out_valid !== 1'b1 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        check("bp_stable", {31'd0, stable}, 32'd1);
        check("bp_result", result, 32'h3EAAAAAB);
        handshake("bp");
        check("bp_result_retained", result, 32'h3EAAAAAB);
        run_op(32'h40C00000, 32'h40000000, lat);
        check("b2b_latency", lat, 28);
        check("b2b_result", result, 32'h40400000);
        check("b2b_flags", {28'd0, flags_now()}, 32'd0);
        handshake("b2b");

        // Reset at T+10 while dividing abandons the operation.
        a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("mid_reset_result", result, 32'd0);
        check("mid_reset_flags", {28'd0, flags_now()}, 32'd0);
        check("mid_reset_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("mid_reset_no_out_valid", {31'd0, seen}, 32'd0);
        run_op(32'h40000000, 32'h40400000, lat);
        check("post_reset_latency", lat, 28);
        check("post_reset_result", result, 32'h3F2AAAAB);
        handshake("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
